mct_sequencer: RTL and testbench
================================

MCT_SEQUENCER -- requirements
Module: mct_sequencer

Interface
REQ-001 Parameter SELW, default 4, width of the register-select code fields.
REQ-002 SIM_CLK  in  1  sole clock; all state changes on the rising edge.
REQ-003 SIM_RST  in  1  asynchronous, active-low reset.
REQ-004 RUN  in  1  enable for memory-cycle-time (MCT) stepping.
REQ-005 INST_REQ  in  1  instruction-sequencer request for a gated transfer.
REQ-006 INST_RSEL, INST_WSEL  in  SELW each  instruction read-source and write-destination codes.
REQ-007 CTR_REQ  in  1  counter-increment request for a gated transfer.
REQ-008 CTR_RSEL, CTR_WSEL  in  SELW each  counter read and write codes.
REQ-009 T_n  out  12  time pulses T01..T12, active-low one-hot; bit0 is T01.
REQ-010 RT_n, WT_n, CT_n  out  1 each  read, write and clear timing strobes, active-low.
REQ-011 RD_n  out  8  gated read selects, active-low one-hot, order {RA,RL,RQ,RZ,RB,RG,RU,RCH}.
REQ-012 WR_n  out  8  gated write selects, active-low one-hot, same order.
REQ-013 GRANT_INST, GRANT_CTR  out  1 each  owner of the current MCT, active-high.
REQ-014 MCT_DONE  out  1  high for the T12 cycle of every MCT.

Function
REQ-015 Sequencer states SHALL be IDLE and TP1..TP12, held in a 4-bit registered counter plus an idle flag.
REQ-016 In IDLE with RUN=1 at a clock edge, the next state SHALL be TP1; with RUN=0 it SHALL remain IDLE.
REQ-017 TPk SHALL advance to TPk+1 on each edge for k=1..11, regardless of RUN.
REQ-018 From TP12 the next state SHALL be TP1 if RUN=1, else IDLE; RUN deasserted mid-MCT completes the MCT through TP12.
REQ-019 T_n bit k-1 SHALL be 0 exactly in TPk; in IDLE all T_n bits SHALL be 1.
REQ-020 Arbitration SHALL occur only on the edge entering TP1; CTR_REQ SHALL have priority over INST_REQ.
REQ-021 The winner's grant SHALL assert on TP1 entry and hold through TP12; at most one grant SHALL be high at any time.
REQ-022 With no request at TP1 entry, both grants SHALL stay low and no select or strobe SHALL assert for that MCT.
REQ-023 The winner's RSEL/WSEL SHALL be latched on TP1 entry; later changes to requests or selects SHALL not affect the current MCT.
REQ-024 RT_n SHALL be 0 in TP7, WT_n 0 in TP8 and CT_n 0 in TP10, only while a grant is held.
REQ-025 RD_n[code] SHALL be 0 during TP7 and WR_n[code] 0 during TP8 for latched codes 0..7; codes 8..15 SHALL select nothing (null transfer).
REQ-026 If the latched RSEL equals the latched WSEL, both transfers SHALL still occur in their own time pulses.
REQ-027 A requester SHALL hold its REQ until its grant is seen; the block SHALL not queue requests.
REQ-028 All outputs SHALL be driven from registers, with no combinational path from any input to any output.

Reset
REQ-029 SIM_RST=0 SHALL immediately force IDLE: T_n=12'hFFF, RT_n=WT_n=CT_n=1, RD_n=WR_n=8'hFF, grants=0, MCT_DONE=0, latched selects=0.
REQ-030 Reset asserted mid-MCT SHALL abort the transfer with no further strobes.
REQ-031 After SIM_RST release, the first possible TP1 SHALL follow the first edge at which RUN=1.

Verification
REQ-032 Reset, then RUN=1 with no requests -> T_n walks 12'hFFE..12'h7FF cyclically, period 12 clocks; no strobes; MCT_DONE high 1 of 12 cycles.
REQ-033 INST_REQ=1, INST_RSEL=0, INST_WSEL=3 -> GRANT_INST for 12 cycles, RD_n=8'hFE with RT_n=0 in TP7, WR_n=8'hF7 with WT_n=0 in TP8, CT_n=0 in TP10.
REQ-034 CTR_REQ and INST_REQ both high at TP1 entry, CTR_RSEL=6 -> GRANT_CTR only, RD_n=8'hBF in TP7; the INST request wins the next MCT once CTR_REQ drops.
REQ-035 RUN dropped in TP4 -> TP5..TP12 complete, then IDLE with T_n=12'hFFF; RUN re-raised -> TP1 on the next cycle.
REQ-036 SIM_RST pulsed low in TP7 of a granted MCT -> all outputs at reset values within the same cycle; no WT_n pulse follows.
REQ-037 INST_WSEL=9 granted -> WT_n still 0 in TP8 while WR_n stays 8'hFF.

Source files
------------

// File: rtl/mct_sequencer_if.sv
// rtl/mct_sequencer_if.sv - request/select inputs and timing/select outputs of the MCT sequencer
interface mct_sequencer_if #(
  parameter int SELW = 4
);
  logic            RUN;
  logic            INST_REQ;
  logic [SELW-1:0] INST_RSEL;
  logic [SELW-1:0] INST_WSEL;
  logic            CTR_REQ;
  logic [SELW-1:0] CTR_RSEL;
  logic [SELW-1:0] CTR_WSEL;
  logic [11:0]     T_n;
  logic            RT_n;
  logic            WT_n;
  logic            CT_n;
  logic [7:0]      RD_n;
  logic [7:0]      WR_n;
  logic            GRANT_INST;
  logic            GRANT_CTR;
  logic            MCT_DONE;

  modport slave (
    input  RUN, INST_REQ, INST_RSEL, INST_WSEL, CTR_REQ, CTR_RSEL, CTR_WSEL,
    output T_n, RT_n, WT_n, CT_n, RD_n, WR_n, GRANT_INST, GRANT_CTR, MCT_DONE
  );

  modport master (
    output RUN, INST_REQ, INST_RSEL, INST_WSEL, CTR_REQ, CTR_RSEL, CTR_WSEL,
    input  T_n, RT_n, WT_n, CT_n, RD_n, WR_n, GRANT_INST, GRANT_CTR, MCT_DONE
  );
endinterface

// File: rtl/mct_sequencer.sv
// rtl/mct_sequencer.sv - twelve-pulse memory-cycle-time sequencer with gated register transfers
module mct_sequencer #(
  parameter int SELW = 4
) (
  input  logic            SIM_CLK,
  input  logic            SIM_RST,
  mct_sequencer_if.slave  bus
);
  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  localparam logic [SELW:0] NUM_SEL = (SELW+1)'(8);

  state_e          r_state, w_state_nxt;
  logic [3:0]      r_tp, w_tp_nxt;
  logic            r_gi, r_gc, w_gi_nxt, w_gc_nxt;
  logic [SELW-1:0] r_rsel, r_wsel, w_rsel_nxt, w_wsel_nxt;
  logic            w_enter, w_active, w_grant, w_rd_ok, w_wr_ok;
  logic [11:0]     r_t_n, w_t_n;
  logic            r_rt_n, r_wt_n, r_ct_n, r_done;
  logic            w_rt_n, w_wt_n, w_ct_n, w_done;
  logic [7:0]      r_rd_n, r_wr_n, w_rd_n, w_wr_n;

  // Next state and arbitration; r_tp holds TPk as k-1.
  always_comb begin
    w_state_nxt = r_state;
    w_tp_nxt    = r_tp;
    w_gi_nxt    = r_gi;
    w_gc_nxt    = r_gc;
    w_rsel_nxt  = r_rsel;
    w_wsel_nxt  = r_wsel;
    case (r_state)
      ST_IDLE: begin
        w_tp_nxt = 4'd0;
        if (bus.RUN) w_state_nxt = ST_RUN;
      end
      default: begin
        if (r_tp == 4'd11) begin
          w_tp_nxt = 4'd0;
          if (!bus.RUN) w_state_nxt = ST_IDLE;
        end else begin
          w_tp_nxt = r_tp + 4'd1;
        end
      end
    endcase
    w_active = (w_state_nxt == ST_RUN);
    w_enter  = w_active && (w_tp_nxt == 4'd0);
    if (!w_active) begin
      w_gi_nxt = 1'b0;
      w_gc_nxt = 1'b0;
    end else if (w_enter) begin
      w_gc_nxt = bus.CTR_REQ;
      w_gi_nxt = bus.INST_REQ && !bus.CTR_REQ;
      if (bus.CTR_REQ) begin
        w_rsel_nxt = bus.CTR_RSEL;
        w_wsel_nxt = bus.CTR_WSEL;
      end else if (bus.INST_REQ) begin
        w_rsel_nxt = bus.INST_RSEL;
        w_wsel_nxt = bus.INST_WSEL;
      end else begin
        w_rsel_nxt = '0;
        w_wsel_nxt = '0;
      end
    end
    w_grant = w_gi_nxt || w_gc_nxt;
    w_rd_ok = ({1'b0, w_rsel_nxt} < NUM_SEL);
    w_wr_ok = ({1'b0, w_wsel_nxt} < NUM_SEL);
  end

  // Outputs are decoded from the next state so the registered copy lines up with r_state.
  always_comb begin
    w_t_n  = '1;
    w_rd_n = '1;
    w_wr_n = '1;
    w_rt_n = 1'b1;
    w_wt_n = 1'b1;
    w_ct_n = 1'b1;
    w_done = 1'b0;
    if (w_active) begin
      w_t_n  = ~(12'd1 << w_tp_nxt);
      w_done = (w_tp_nxt == 4'd11);
      if (w_grant) begin
        w_rt_n = !(w_tp_nxt == 4'd6);
        w_wt_n = !(w_tp_nxt == 4'd7);
        w_ct_n = !(w_tp_nxt == 4'd9);
        if (w_tp_nxt == 4'd6 && w_rd_ok) w_rd_n = ~(8'd1 << w_rsel_nxt[2:0]);
        if (w_tp_nxt == 4'd7 && w_wr_ok) w_wr_n = ~(8'd1 << w_wsel_nxt[2:0]);
      end
    end
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      r_state <= ST_IDLE;
      r_tp    <= 4'd0;
      r_gi    <= 1'b0;
      r_gc    <= 1'b0;
      r_rsel  <= '0;
      r_wsel  <= '0;
      r_t_n   <= '1;
      r_rd_n  <= '1;
      r_wr_n  <= '1;
      r_rt_n  <= 1'b1;
      r_wt_n  <= 1'b1;
      r_ct_n  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tp    <= w_tp_nxt;
      r_gi    <= w_gi_nxt;
      r_gc    <= w_gc_nxt;
      r_rsel  <= w_rsel_nxt;
      r_wsel  <= w_wsel_nxt;
      r_t_n   <= w_t_n;
      r_rd_n  <= w_rd_n;
      r_wr_n  <= w_wr_n;
      r_rt_n  <= w_rt_n;
      r_wt_n  <= w_wt_n;
      r_ct_n  <= w_ct_n;
      r_done  <= w_done;
    end
  end

  assign bus.T_n        = r_t_n;
  assign bus.RT_n       = r_rt_n;
  assign bus.WT_n       = r_wt_n;
  assign bus.CT_n       = r_ct_n;
  assign bus.RD_n       = r_rd_n;
  assign bus.WR_n       = r_wr_n;
  assign bus.GRANT_INST = r_gi;
  assign bus.GRANT_CTR  = r_gc;
  assign bus.MCT_DONE   = r_done;
endmodule

// File: tb/tb_mct_sequencer.sv
// tb/tb_mct_sequencer.sv - scoreboard bench for mct_sequencer
module tb_mct_sequencer;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [33:0] sb_q[$];
  string       tag_q[$];

  mct_sequencer_if #(.SELW(4)) bus ();

  mct_sequencer #(.SELW(4)) u_dut (
    .SIM_CLK (clk),
    .SIM_RST (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // k = 0 is IDLE, k = 1..12 is TPk
  function automatic logic [33:0] exp_vec(input int k, input bit gi, input bit gc, input int rs, input int ws);
    logic [11:0] t;
    logic [7:0]  rd, wr;
    logic        g;
    g  = (k != 0) && (gi || gc);
    t  = (k == 0) ? 12'hFFF : ~(12'd1 << (k - 1));
    rd = (g && k == 7 && rs < 8) ? ~(8'd1 << rs) : 8'hFF;
    wr = (g && k == 8 && ws < 8) ? ~(8'd1 << ws) : 8'hFF;
    return {t, !(g && k == 7), !(g && k == 8), !(g && k == 10), rd, wr,
            (k != 0) && gi, (k != 0) && gc, k == 12};
  endfunction

  function automatic logic [33:0] observed();
    return {bus.T_n, bus.RT_n, bus.WT_n, bus.CT_n, bus.RD_n, bus.WR_n,
            bus.GRANT_INST, bus.GRANT_CTR, bus.MCT_DONE};
  endfunction

  task automatic push(input string tag, input logic [33:0] v);
    sb_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic sample();
    logic [33:0] e;
    string       t;
    if (sb_q.size() == 0) begin
      check_vec("sb_underflow", observed(), 34'h0);
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check_vec(t, observed(), e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic idle_steps(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      push($sformatf("%s_idle%0d", tag, i), exp_vec(0, 0, 0, 0, 0));
      step();
    end
  endtask

  // One full MCT; the winner drops its request and scrambles its selects after the grant is seen.
  task automatic mct(input string tag, input bit gi, input bit gc, input int rs, input int ws,
                     input int drop_run_at);
    for (int k = 1; k <= 12; k++)
      push($sformatf("%s_tp%0d", tag, k), exp_vec(k, gi, gc, rs, ws));
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) begin
        if (gc) begin
          bus.CTR_REQ  = 1'b0;
          bus.CTR_RSEL = 4'($urandom_range(0, 15));
          bus.CTR_WSEL = 4'($urandom_range(0, 15));
        end
        if (gi) begin
          bus.INST_REQ  = 1'b0;
          bus.INST_RSEL = 4'($urandom_range(0, 15));
          bus.INST_WSEL = 4'($urandom_range(0, 15));
        end
      end
      if (k == drop_run_at) bus.RUN = 1'b0;
    end
  endtask

  task automatic inst_req(input int rs, input int ws);
    bus.INST_REQ  = 1'b1;
    bus.INST_RSEL = 4'(rs);
    bus.INST_WSEL = 4'(ws);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n         = 1'b0;
    bus.RUN       = 1'b0;
    bus.INST_REQ  = 1'b0;
    bus.INST_RSEL = '0;
    bus.INST_WSEL = '0;
    bus.CTR_REQ   = 1'b0;
    bus.CTR_RSEL  = '0;
    bus.CTR_WSEL  = '0;

    idle_steps("reset", 2);
    rst_n = 1'b1;
    idle_steps("run_low", 2);

    bus.RUN = 1'b1;
    mct("free0", 0, 0, 0, 0, 0);
    mct("free1", 0, 0, 0, 0, 0);

    inst_req(0, 3);
    mct("inst03", 1, 0, 0, 3, 0);

    inst_req(1, 5);
    bus.CTR_REQ  = 1'b1;
    bus.CTR_RSEL = 4'd6;
    bus.CTR_WSEL = 4'd2;
    mct("ctr_wins", 0, 1, 6, 2, 0);
    mct("inst_next", 1, 0, 1, 5, 0);

    inst_req(4, 4);
    mct("same_sel", 1, 0, 4, 4, 0);

    inst_req(2, 9);
    mct("null_wr", 1, 0, 2, 9, 0);

    inst_req(11, 7);
    mct("null_rd", 1, 0, 11, 7, 0);

    mct("run_drop", 0, 0, 0, 0, 4);
    idle_steps("after_drop", 3);
    bus.RUN = 1'b1;
    mct("rerun", 0, 0, 0, 0, 0);

    inst_req(0, 3);
    for (int k = 1; k <= 7; k++)
      push($sformatf("abort_tp%0d", k), exp_vec(k, 1, 0, 0, 3));
    for (int k = 1; k <= 7; k++) step();
    rst_n = 1'b0;
    #1;
    push("abort_async", exp_vec(0, 0, 0, 0, 0));
    sample();
    bus.RUN      = 1'b0;
    bus.INST_REQ = 1'b0;
    idle_steps("abort_held", 2);
    rst_n = 1'b1;
    idle_steps("abort_rel", 3);
    bus.RUN = 1'b1;
    mct("post_rst", 0, 0, 0, 0, 12);
    idle_steps("final", 2);

    check_vec("sb_drained", 34'(sb_q.size()), 34'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
